branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 114 +++++++++++
 tb/tb_branch_resolve.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: direct-mapped BTB with 2-bit counters, mispredict detection,
// a one-cycle redirect/shadow state and resolve/mispredict statistics.
module branch_resolve #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        br_en,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] SHADOW = 1'b1;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [0:0]        state_q;
    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              if_hit;
    logic              ex_hit;
    logic              resolve;
    logic              mispredict;
    logic              unused_pc_bits;

    assign if_idx = if_pc[2 +: IDX_W];
    assign if_tag = if_pc[31 -: TAG_W];
    assign ex_idx = ex_pc[2 +: IDX_W];
    assign ex_tag = ex_pc[31 -: TAG_W];

    // The byte offset within the instruction word never participates in prediction.
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_pred_taken  = if_hit && ctr_q[if_idx][1];
    assign if_pred_target = if_pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign resolve = ex_valid && ex_is_branch && (state_q == RUN);

    // A correctly-predicted taken branch can still mispredict if the carried target is stale.
    assign mispredict = resolve &&
                        ((br_en != ex_pred_taken) ||
                         (br_en && ex_pred_taken && (ex_pred_target != ex_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (resolve) begin
            if (ex_hit) begin
                if (br_en) begin
                    if (ctr_q[ex_idx] != 2'b11) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end
                    target_q[ex_idx] <= ex_target;
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (br_en) begin
                // Not-taken misses are not worth an entry; they would predict not-taken anyway.
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                ctr_q[ex_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= RUN;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve) begin
                branch_count <= branch_count + 32'd1;
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
                redirect_pc      <= br_en ? ex_target : (ex_pc + 32'd4);
            end
            state_q <= mispredict ? SHADOW : RUN;
        end
    end

    assign redirect_valid = (state_q == SHADOW);

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed vector table, reset-in-shadow sequence,
// and randomized traffic checked against an abstract predictor model.
module tb_branch_resolve;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = $clog2(ENTRIES);

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        br_en;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks;
    int failures;

    branch_resolve #(.ENTRIES(ENTRIES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .br_en            (br_en),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        exp_pt;
        logic [31:0] exp_ptgt;
        logic        ex_valid;
        logic        ex_is_branch;
        logic [31:0] ex_pc;
        logic [31:0] ex_target;
        logic        br_en;
        logic        ex_pred_taken;
        logic [31:0] ex_pred_target;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        logic [31:0] exp_bc;
        logic [31:0] exp_mc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic [31:0] ipc, input logic pt, input logic [31:0] ptgt,
                                input logic v, input logic b, input logic [31:0] pc,
                                input logic [31:0] tgt, input logic br, input logic ppt,
                                input logic [31:0] pptgt, input logic rv, input logic [31:0] rpc,
                                input logic [31:0] bc, input logic [31:0] mc);
        vec_t r;
        r.if_pc = ipc; r.exp_pt = pt; r.exp_ptgt = ptgt;
        r.ex_valid = v; r.ex_is_branch = b; r.ex_pc = pc; r.ex_target = tgt;
        r.br_en = br; r.ex_pred_taken = ppt; r.ex_pred_target = pptgt;
        r.exp_rv = rv; r.exp_rpc = rpc; r.exp_bc = bc; r.exp_mc = mc;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        if_pc          = v.if_pc;
        ex_valid       = v.ex_valid;
        ex_is_branch   = v.ex_is_branch;
        ex_pc          = v.ex_pc;
        ex_target      = v.ex_target;
        br_en          = v.br_en;
        ex_pred_taken  = v.ex_pred_taken;
        ex_pred_target = v.ex_pred_target;
    endtask

    // Abstract predictor model: per-entry state kept as plain integers.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_shadow;
    logic [31:0] m_rpc, m_bc, m_mc;

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
        end
        m_shadow = 0; m_rpc = 0; m_bc = 0; m_mc = 0;
    endtask

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] pc);
        return int'(pc >> (2 + IDX_W));
    endfunction

    function automatic bit m_predict(input logic [31:0] pc);
        int i;
        i = m_index(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic model_cycle(input vec_t v);
        bit pt, res, mis;
        int i;
        logic [31:0] ptgt;
        drive(v);
        #1;
        pt   = m_predict(v.if_pc);
        ptgt = pt ? m_target[m_index(v.if_pc)] : v.if_pc + 32'd4;
        check("lookup_taken", {31'd0, if_pred_taken}, {31'd0, pt});
        check("lookup_target", if_pred_target, ptgt);
        res = v.ex_valid && v.ex_is_branch && !m_shadow;
        mis = res && ((v.br_en != v.ex_pred_taken) ||
                      (v.br_en && v.ex_pred_taken && v.ex_pred_target != v.ex_target));
        if (res) begin
            i = m_index(v.ex_pc);
            m_bc++;
            if (m_valid[i] && m_tag[i] == m_tagof(v.ex_pc)) begin
                if (v.br_en) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = v.ex_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (v.br_en) begin
                m_valid[i] = 1; m_tag[i] = m_tagof(v.ex_pc);
                m_target[i] = v.ex_target; m_ctr[i] = 2;
            end
        end
        if (mis) begin
            m_mc++;
            m_rpc = v.br_en ? v.ex_target : v.ex_pc + 32'd4;
        end
        m_shadow = mis;
        @(posedge clk);
        #1;
        check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_shadow});
        check("redirect_pc", redirect_pc, m_rpc);
        check("branch_count", branch_count, m_bc);
        check("mispredict_count", mispredict_count, m_mc);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags[5];
        tags[0] = 0; tags[1] = 1; tags[2] = 2; tags[3] = 3; tags[4] = 32'h03FF_FFFF;
        return (tags[$urandom_range(0, 4)] << (2 + IDX_W)) |
               (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] pool[4];
        pool[0] = 32'h1000; pool[1] = 32'h2000; pool[2] = 32'h3000; pool[3] = $urandom;
        return pool[$urandom_range(0, 3)];
    endfunction

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        v = mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);

        vecs[0]  = mk(32'h100, 0, 32'h104, 1, 1, 32'h100, 32'h200, 1, 0, 0,       1, 32'h200, 1, 1);
        vecs[1]  = mk(32'h100, 1, 32'h200, 1, 1, 32'h100, 32'h0,   0, 1, 32'h200, 0, 32'h200, 1, 1);
        vecs[2]  = mk(32'h100, 1, 32'h200, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 1, 32'h104, 2, 2);
        vecs[3]  = mk(32'h100, 0, 32'h104, 1, 1, 32'h100, 32'h200, 1, 0, 0,       0, 32'h104, 2, 2);
        vecs[4]  = mk(32'h100, 0, 32'h104, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 1, 32'h104, 3, 3);
        vecs[5]  = mk(32'h100, 0, 32'h104, 1, 1, 32'h100, 32'h0,   1, 0, 0,       0, 32'h104, 3, 3);
        vecs[6]  = mk(32'h100, 0, 32'h104, 1, 1, 32'h100, 32'h200, 0, 0, 0,       0, 32'h104, 4, 3);
        vecs[7]  = mk(32'h204, 0, 32'h208, 1, 1, 32'h204, 32'h300, 1, 0, 0,       1, 32'h300, 5, 4);
        vecs[8]  = mk(32'h204, 1, 32'h300, 0, 0, 32'h0,   32'h0,   0, 0, 0,       0, 32'h300, 5, 4);
        vecs[9]  = mk(32'h204, 1, 32'h300, 1, 1, 32'h204, 32'h400, 1, 1, 32'h300, 1, 32'h400, 6, 5);
        vecs[10] = mk(32'h204, 1, 32'h400, 0, 0, 32'h0,   32'h0,   0, 0, 0,       0, 32'h400, 6, 5);
        vecs[11] = mk(32'h204, 1, 32'h400, 1, 0, 32'h204, 32'h0,   0, 1, 0,       0, 32'h400, 6, 5);
        vecs[12] = mk(32'hFFFF_FFFC, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h0, 0, 1, 0, 1, 32'h0, 7, 6);
        vecs[13] = mk(32'hFFFF_FFFC, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0,        0, 32'h0, 7, 6);
        vecs[14] = mk(32'h204, 1, 32'h400, 1, 1, 32'h204, 32'h400, 1, 1, 32'h400, 0, 32'h0, 8, 6);

        repeat (3) @(posedge clk);
        #1;
        check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_branch_count", branch_count, 32'd0);
        check("rst_mispredict_count", mispredict_count, 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k]);
            #1;
            check($sformatf("vec%0d_pred_taken", k), {31'd0, if_pred_taken}, {31'd0, vecs[k].exp_pt});
            check($sformatf("vec%0d_pred_target", k), if_pred_target, vecs[k].exp_ptgt);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_redirect_valid", k), {31'd0, redirect_valid}, {31'd0, vecs[k].exp_rv});
            check($sformatf("vec%0d_redirect_pc", k), redirect_pc, vecs[k].exp_rpc);
            check($sformatf("vec%0d_branch_count", k), branch_count, vecs[k].exp_bc);
            check($sformatf("vec%0d_mispredict_count", k), mispredict_count, vecs[k].exp_mc);
        end

        // Reset landing in the shadow cycle must kill the redirect at once.
        drive(mk(32'h100, 0, 0, 1, 1, 32'h204, 32'h500, 1, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("shadow_entry_valid", {31'd0, redirect_valid}, 32'd1);
        check("shadow_entry_pc", redirect_pc, 32'h500);
        check("shadow_entry_bc", branch_count, 32'd9);
        check("shadow_entry_mc", mispredict_count, 32'd7);
        drive(mk(32'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("async_rst_redirect_pc", redirect_pc, 32'd0);
        check("async_rst_branch_count", branch_count, 32'd0);
        check("async_rst_mispredict_count", mispredict_count, 32'd0);
        check("async_rst_lookup_204", {31'd0, if_pred_taken}, 32'd0);
        check("async_rst_target_204", if_pred_target, 32'h208);
        if_pc = 32'h100;
        #1;
        check("async_rst_lookup_100", {31'd0, if_pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        check("held_rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        model_reset();

        // First edge after reset release resolves a branch immediately.
        model_cycle(mk(32'h100, 0, 0, 1, 1, 32'h100, 32'h200, 1, 0, 0, 0, 0, 0, 0));
        check("first_edge_branch_count", branch_count, 32'd1);

        for (int n = 0; n < 400; n++) begin
            v.if_pc        = ($urandom_range(0, 1) == 0) ? rand_pc() : v.ex_pc;
            v.ex_valid     = ($urandom_range(0, 3) != 0);
            v.ex_is_branch = ($urandom_range(0, 4) != 0);
            v.ex_pc        = rand_pc();
            v.ex_target    = rand_target();
            v.br_en        = $urandom_range(0, 1);
            if ($urandom_range(0, 3) != 0) begin
                v.ex_pred_taken  = m_predict(v.ex_pc);
                v.ex_pred_target = v.ex_pred_taken ? m_target[m_index(v.ex_pc)] : v.ex_pc + 32'd4;
            end else begin
                v.ex_pred_taken  = $urandom_range(0, 1);
                v.ex_pred_target = rand_target();
            end
            model_cycle(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
